// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one memory bus between fetch (read-only) and load/store, data first with a fetch anti-starvation limit.
// Optional bus timeout enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_data,
  output logic        o_fetch_error,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_ready,
  output logic [31:0] o_data_rdata,
  output logic        o_data_error,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_q;
  logic [SW-1:0] streak_q, streak_d;
  logic owner_data_q, pick_data;
  logic bus_req_q, bus_rw_q, fready_q, dready_q;
  logic [31:0] addr_q, wdata_q, fdata_q, drdata_q;
  always_comb begin
    pick_data = i_data_request && (!i_fetch_request || streak_q != SW'(DATA_STREAK_MAX));
    streak_d  = (pick_data && i_fetch_request) ? streak_q + 1'b1 : '0;
  end
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_fetch_ready = fready_q;
  assign o_fetch_data  = fdata_q;
  assign o_data_ready  = dready_q;
  assign o_data_rdata  = drdata_q;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic ferr_q, derr_q, timeout;
  assign timeout       = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign o_fetch_error = ferr_q;
  assign o_data_error  = derr_q;
`else
  assign o_fetch_error = 1'b0;
  assign o_data_error  = 1'b0;
`endif
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      owner_data_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_rw_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fready_q     <= 1'b0;
      dready_q     <= 1'b0;
      fdata_q      <= '0;
      drdata_q     <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      tcnt_q       <= '0;
      ferr_q       <= 1'b0;
      derr_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (i_fetch_request || i_data_request) begin
          state_q      <= ACTIVE;
          bus_req_q    <= 1'b1;
          owner_data_q <= pick_data;
          bus_rw_q     <= pick_data && i_data_rw;
          addr_q       <= pick_data ? i_data_address : i_fetch_address;
          wdata_q      <= pick_data ? i_data_wdata : '0;
          streak_q     <= streak_d;
`ifdef CPU_BUS_TIMEOUT_EN
          tcnt_q       <= '0;
`endif
        end
        ACTIVE: if (i_bus_ready) begin
          state_q   <= DONE;
          bus_req_q <= 1'b0;
          if (owner_data_q) begin
            dready_q <= 1'b1;
            if (!bus_rw_q) drdata_q <= i_bus_rdata;
          end else begin
            fready_q <= 1'b1;
            fdata_q  <= i_bus_rdata;
          end
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (timeout) begin
          // abort: report error to the owner and return zeroed read data
          state_q   <= DONE;
          bus_req_q <= 1'b0;
          if (owner_data_q) begin
            dready_q <= 1'b1;
            derr_q   <= 1'b1;
            if (!bus_rw_q) drdata_q <= '0;
          end else begin
            fready_q <= 1'b1;
            ferr_q   <= 1'b1;
            fdata_q  <= '0;
          end
        end else tcnt_q <= tcnt_q + 1'b1;
`endif
        default: begin
          state_q  <= IDLE;
          fready_q <= 1'b0;
          dready_q <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
          ferr_q   <= 1'b0;
          derr_q   <= 1'b0;
`endif
        end
      endcase
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed scenarios plus randomized transactions against a transaction-level arbitration model.
module tb_cpu_bus_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic freq = 0, dreq = 0, drw = 0, bready = 0;
  logic [31:0] faddr = 0, daddr = 0, dwdata = 0, brdata = 0;
  logic fready, ferr, dready, derr, breq, brw;
  logic [31:0] fdata, drdata, baddr, bwdata;
  logic [133:0] all_out;
  int n_cmp = 0, n_bad = 0;
  int m_streak = 0;
  logic [31:0] m_fdata = 0, m_drdata = 0;
  always #5 clk = ~clk;
  cpu_bus_arbiter #(.DATA_STREAK_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_fetch_request(freq), .i_fetch_address(faddr), .o_fetch_ready(fready),
    .o_fetch_data(fdata), .o_fetch_error(ferr),
    .i_data_request(dreq), .i_data_rw(drw), .i_data_address(daddr), .i_data_wdata(dwdata),
    .o_data_ready(dready), .o_data_rdata(drdata), .o_data_error(derr),
    .o_bus_request(breq), .o_bus_rw(brw), .o_bus_address(baddr), .o_bus_wdata(bwdata),
    .i_bus_ready(bready), .i_bus_rdata(brdata)
  );
  assign all_out = {breq, brw, baddr, bwdata, fready, fdata, ferr, dready, drdata, derr};
  // data wins unless fetch waits and data has already won DATA_STREAK_MAX times in a row
  function automatic bit model_grant(bit f, bit d);
    bit w;
    w = d && (!f || m_streak != 4);
    m_streak = (w && f) ? m_streak + 1 : 0;
    return w;
  endfunction
  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (breq) ok = 1;
    end
  endtask
  task automatic bus_respond(input int dly, input logic [31:0] rd);
    repeat (dly) begin @(posedge clk); #1; end
    bready = 1; brdata = rd;
    @(posedge clk); #1;
    bready = 0;
  endtask
  task automatic test_reset;
    #3;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1 rst_n = 1;
  endtask
  task automatic test_fetch_only;
    bit ok, w;
    @(posedge clk); #1 freq = 1; faddr = 32'h100;
    w = model_grant(1, 0);
    wait_grant(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fetch_grant: got no grant want grant"); end
    n_cmp++; if ({brw, baddr, bwdata} !== {1'b0, 32'h100, 32'h0}) begin n_bad++; $display("FAIL fetch_bus: got rw=%b a=%h wd=%h want rw=0 a=100 wd=0", brw, baddr, bwdata); end
    bus_respond(1, 32'hDEADBEEF);
    m_fdata = 32'hDEADBEEF;
    n_cmp++; if ({fready, dready, fdata} !== {2'b10, 32'hDEADBEEF}) begin n_bad++; $display("FAIL fetch_ready: got fr=%b dr=%b d=%h want fr=1 dr=0 d=deadbeef", fready, dready, fdata); end
    freq = 0;
    @(posedge clk); #1;
    n_cmp++; if ({fready, breq} !== 2'b00) begin n_bad++; $display("FAIL fetch_pulse_once: got fr=%b req=%b want 0 0", fready, breq); end
  endtask
  task automatic test_priority;
    bit ok, w;
    logic [31:0] old_d;
    old_d = drdata;
    @(posedge clk); #1 freq = 1; faddr = 32'h100; dreq = 1; drw = 1; daddr = 32'h2000; dwdata = 32'h55;
    w = model_grant(1, 1);
    wait_grant(ok);
    n_cmp++; if (!ok || {brw, baddr, bwdata} !== {1'b1, 32'h2000, 32'h55}) begin n_bad++; $display("FAIL prio_data_first: got ok=%b rw=%b a=%h wd=%h want rw=1 a=2000 wd=55", ok, brw, baddr, bwdata); end
    bus_respond(0, 32'h1234_5678);
    n_cmp++; if ({dready, fready, drdata} !== {2'b10, old_d}) begin n_bad++; $display("FAIL prio_data_ready: got dr=%b fr=%b rd=%h want 1 0 %h", dready, fready, drdata, old_d); end
    dreq = 0;
    w = model_grant(1, 0);
    wait_grant(ok);
    n_cmp++; if (!ok || {brw, baddr, bwdata} !== {1'b0, 32'h100, 32'h0}) begin n_bad++; $display("FAIL prio_fetch_second: got ok=%b rw=%b a=%h wd=%h want rw=0 a=100 wd=0", ok, brw, baddr, bwdata); end
    bus_respond(2, 32'hCAFE_0001);
    m_fdata = 32'hCAFE_0001;
    n_cmp++; if ({fready, fdata, drdata} !== {1'b1, 32'hCAFE_0001, old_d}) begin n_bad++; $display("FAIL prio_fetch_ready: got fr=%b fd=%h rd=%h want 1 cafe0001 %h", fready, fdata, drdata, old_d); end
    freq = 0;
  endtask
  task automatic test_starvation;
    bit ok, w;
    string got, exp;
    got = ""; exp = "DDDDFDDDDF";
    @(posedge clk); #1 freq = 1; faddr = 32'h100; dreq = 1; drw = 0; daddr = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      w = model_grant(1, 1);
      wait_grant(ok);
      got = {got, (!ok) ? "X" : (baddr == 32'h2000) ? "D" : (baddr == 32'h100) ? "F" : "?"};
      bus_respond(0, 32'h1000 + i);
      if (w) m_drdata = 32'h1000 + i; else m_fdata = 32'h1000 + i;
    end
    freq = 0; dreq = 0;
    n_cmp++; if (got != exp) begin n_bad++; $display("FAIL starvation_order: got %s want %s", got, exp); end
  endtask
  task automatic test_spurious;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bready = 1; brdata = $urandom;
      @(posedge clk); #1;
      n_cmp++; if ({breq, fready, dready, fdata, drdata} !== {3'b000, m_fdata, m_drdata}) begin n_bad++; $display("FAIL spurious_ready: got req=%b fr=%b dr=%b fd=%h rd=%h want 0 0 0 %h %h", breq, fready, dready, fdata, drdata, m_fdata, m_drdata); end
    end
    bready = 0;
  endtask
  task automatic test_timeout;
    bit ok, w;
    @(posedge clk); #1 dreq = 1; drw = 0; daddr = 32'h3000;
    w = model_grant(0, 1);
    wait_grant(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_grant: got no grant want grant"); end
`ifdef CPU_BUS_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({breq, dready} !== 2'b10) begin n_bad++; $display("FAIL timeout_early: cycle %0d got req=%b dr=%b want 1 0", i, breq, dready); end
    end
    @(posedge clk); #1;
    m_drdata = 0;
    n_cmp++; if ({breq, dready, derr, drdata} !== {3'b011, 32'h0}) begin n_bad++; $display("FAIL timeout_abort: got req=%b dr=%b err=%b rd=%h want 0 1 1 0", breq, dready, derr, drdata); end
    dreq = 0; bready = 1; brdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    n_cmp++; if ({dready, derr, drdata} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL timeout_clear: got dr=%b err=%b rd=%h want 0 0 0", dready, derr, drdata); end
    @(posedge clk); #1 bready = 0;
    n_cmp++; if ({breq, dready, drdata} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL timeout_late_ready: got req=%b dr=%b rd=%h want 0 0 0", breq, dready, drdata); end
`else
    repeat (12) begin @(posedge clk); #1; end
    n_cmp++; if ({breq, dready, derr, ferr} !== 4'b1000) begin n_bad++; $display("FAIL no_timeout_hold: got req=%b dr=%b derr=%b ferr=%b want 1 0 0 0", breq, dready, derr, ferr); end
    bus_respond(0, 32'h7777_0000);
    m_drdata = 32'h7777_0000;
    n_cmp++; if ({dready, derr, drdata} !== {2'b10, 32'h7777_0000}) begin n_bad++; $display("FAIL no_timeout_done: got dr=%b err=%b rd=%h want 1 0 77770000", dready, derr, drdata); end
    dreq = 0;
`endif
  endtask
  task automatic test_random;
    bit ok, w, erw;
    logic [31:0] ea, ewd, rd;
    for (int t = 0; t < 60; t++) begin
      if (!freq && $urandom_range(1) == 1) begin freq = 1; faddr = $urandom; end
      if (!dreq && $urandom_range(1) == 1) begin dreq = 1; drw = 1'($urandom_range(1)); daddr = $urandom; dwdata = $urandom; end
      if (!freq && !dreq) begin freq = 1; faddr = $urandom; end
      w = model_grant(freq, dreq);
      ea = w ? daddr : faddr; erw = w && drw; ewd = w ? dwdata : 32'h0;
      wait_grant(ok);
      n_cmp++; if (!ok || {brw, baddr, bwdata} !== {erw, ea, ewd}) begin n_bad++; $display("FAIL rand_bus[%0d]: got ok=%b rw=%b a=%h wd=%h want rw=%b a=%h wd=%h", t, ok, brw, baddr, bwdata, erw, ea, ewd); end
      if ($urandom_range(3) == 0) begin if (w) dreq = 0; else freq = 0; end
      rd = $urandom;
      bus_respond($urandom_range(4), rd);
      if (!w) m_fdata = rd; else if (!erw) m_drdata = rd;
      n_cmp++; if ({dready, fready, derr, ferr, fdata, drdata} !== {w, !w, 2'b00, m_fdata, m_drdata}) begin n_bad++; $display("FAIL rand_done[%0d]: got dr=%b fr=%b de=%b fe=%b fd=%h rd=%h want %b %b 0 0 %h %h", t, dready, fready, derr, ferr, fdata, drdata, w, !w, m_fdata, m_drdata); end
      if (w) dreq = 0; else freq = 0;
    end
    freq = 0; dreq = 0;
  endtask
  task automatic test_reset_mid;
    bit ok;
    @(posedge clk); #1 freq = 1; faddr = 32'h400;
    wait_grant(ok);
    @(posedge clk); #1 rst_n = 0;
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_mid_outputs: got %h want 0", all_out); end
    freq = 0; m_streak = 0; m_fdata = 0; m_drdata = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({breq, fready, dready} !== 3'b000) begin n_bad++; $display("FAIL reset_mid_after: got req=%b fr=%b dr=%b want 0 0 0", breq, fready, dready); end
    end
  endtask
  initial begin
    test_reset;
    test_fetch_only;
    test_priority;
    test_starvation;
    test_spurious;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
